axis_pkt_arbiter: RTL and testbench
===================================

AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Interface
REQ-001 The block SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, AXIS data width in bits (multiple of 8).
REQ-002 The block SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, AXIS tuser width in bits (>= 32).
REQ-003 The block SHALL have parameter NUM_CH, default 6, number of input packet FIFOs (2..16).
REQ-004 The block SHALL have parameter ARB_MODE, default 1, grant policy (0 = fixed priority, 1 = round-robin).
REQ-005 The block SHALL have parameter REFLECT_CH, default 0, index of the channel whose tuser destination byte is rewritten.
REQ-006 The block SHALL have these ports:
  - axis_aclk  in  1  clock.
  - axis_resetn  in  1  asynchronous active-low reset.
  - i_tdata  in  NUM_CH*DW  per-channel FIFO head data, channel c at slice c.
  - i_tuser  in  NUM_CH*UW  per-channel head tuser.
  - i_tkeep  in  NUM_CH*DW/8  per-channel head tkeep.
  - i_tlast  in  NUM_CH  per-channel head tlast.
  - i_pkt_fifo_empty  in  NUM_CH  per-channel FIFO empty (FWFT FIFOs; head valid when low).
  - o_pkt_fifo_rd_en  out  NUM_CH  per-channel pop strobe.
  - o_axis_opl_tdata/tkeep/tuser/tvalid/tlast  out  DW/DW/8/UW/1/1  merged AXIS output.
  - i_axis_opl_tready  in  1  downstream ready.
  - o_grant  out  clog2(NUM_CH)  currently or last granted channel.
  - o_busy  out  1  high while state is XFER.

Function
REQ-007 The FSM SHALL have two states: IDLE and XFER.
REQ-008 In IDLE, if any i_pkt_fifo_empty bit is low, the block SHALL select a channel and enter XFER on the next clock, with o_grant updated in the same edge.
REQ-009 ARB_MODE=0 SHALL select the lowest-index non-empty channel.
REQ-010 ARB_MODE=1 SHALL select the first non-empty channel searching upward, with wrap, from o_grant+1.
REQ-011 After reset, the round-robin search SHALL start at channel 0.
REQ-012 Output stage "can load" SHALL mean (!o_axis_opl_tvalid || i_axis_opl_tready).
REQ-013 In XFER, o_pkt_fifo_rd_en[g] SHALL be combinationally (can load && !i_pkt_fifo_empty[g]), where g = o_grant.
REQ-014 All other o_pkt_fifo_rd_en bits SHALL be 0.
REQ-015 On a pop, the output register SHALL capture the head word of channel g on the same edge: tdata, tkeep, tlast, tvalid=1. Latency is 1 cycle from pop to tvalid.
REQ-016 If can load is high and no pop occurs, o_axis_opl_tvalid SHALL clear to 0.
REQ-017 While tvalid=1 and tready=0, all output registers SHALL hold stable.
REQ-018 Grant SHALL be packet-atomic: XFER returns to IDLE only on the edge that pops a word with i_tlast[g]=1.
REQ-019 An empty FIFO mid-packet SHALL stall in XFER without releasing the grant.
REQ-020 For g == REFLECT_CH, tuser[31:24] SHALL be rewritten from src = tuser[23:16]: 0x40 -> 0x01, 0x01 -> 0x40, other -> 0x00.
REQ-021 All other tuser bits, and tuser for every other channel, SHALL pass unchanged.
REQ-022 A single-word packet (tlast on first word) SHALL take exactly one XFER cycle when tready=1.
REQ-023 Back-to-back packets SHALL incur exactly one IDLE cycle between the tlast pop and the next first-word pop.
REQ-024 o_busy SHALL be 1 exactly while state is XFER.

Reset
REQ-025 Assertion of axis_resetn=0 SHALL immediately force state IDLE, o_grant=0, and all o_axis_opl_* registers to 0, including mid-packet.
REQ-026 o_pkt_fifo_rd_en SHALL be 0 while reset is asserted.
REQ-027 A packet interrupted by reset SHALL NOT be resumed; upstream FIFO flush is the system's responsibility.
REQ-028 Deassertion SHALL be synchronised externally; the block needs no internal synchroniser.

Structure
REQ-029 A shared package SHALL hold the ARB_MODE encodings, the FSM state encoding and the MAC byte constants 0x40/0x01.
REQ-030 A sub-module axis_rr_picker SHALL hold the combinational next-grant function (request vector, last grant, mode -> grant index, any_req).
REQ-031 Per-channel slicing SHALL use generate or indexed part-selects; no hand-unrolled channel code.

Verification
REQ-032 Ch2 holds a 3-word packet, ch5 a 2-word packet, tready=1, mode 1 -> ch2 words out, one idle cycle, then ch5 words out; o_grant 2 then 5.
REQ-033 Ch0 and ch1 each hold 2 packets, mode 0 -> both ch0 packets drain before any ch1 word; in mode 1 the order is ch0, ch1, ch0, ch1.
REQ-034 Ch3 packet in flight and tready low for 4 cycles mid-packet -> output held stable, no rd_en pulse, no word lost or duplicated.
REQ-035 REFLECT_CH=0, ch0 packet with tuser[23:16]=0x40 -> output tuser[31:24]=0x01; a ch1 packet with the same tuser passes unchanged.
REQ-036 Ch4 goes empty after word 2 of 4 while ch0 is non-empty -> grant stays 4; ch0 is not served until ch4's tlast pops.
REQ-037 Reset asserted mid-packet on ch1 -> tvalid=0, o_grant=0 and rd_en=0 in the same cycle; after release, arbitration restarts from channel 0.

Source files
------------

// File: rtl/axis_pkt_arbiter_pkg.sv
`default_nettype none
//============================================================================
// Module      : axis_pkt_arbiter_pkg
// Description : Shared encodings for the AXIS packet arbiter: grant policies,
//               FSM states and the MAC address bytes used by reflection.
// Revision    : 1.0 - initial release
//============================================================================
package axis_pkt_arbiter_pkg;

   localparam int c_ARB_FIXED = 0;
   localparam int c_ARB_RR    = 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } arb_state_t;

   localparam logic [7:0] c_MAC_HOST = 8'h40;
   localparam logic [7:0] c_MAC_PORT = 8'h01;

   // Swap host/port MAC bytes so a reflected packet is addressed back to its sender.
   function automatic logic [7:0] reflect_dst(input logic [7:0] src);
      logic [7:0] dst;
      if (src == c_MAC_HOST)
         dst = c_MAC_PORT;
      else if (src == c_MAC_PORT)
         dst = c_MAC_HOST;
      else
         dst = 8'h00;
      return dst;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_rr_picker.sv
`default_nettype none
//============================================================================
// Module      : axis_rr_picker
// Description : Combinational next-grant selection, fixed priority or
//               round-robin starting one past the last grant.
// Revision    : 1.0 - initial release
//============================================================================
module axis_rr_picker #(
   parameter int NUM_CH = 6,
   parameter int GW     = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [GW-1:0]     i_last_grant,
   input  logic              i_rr_mode,
   output logic [GW-1:0]     o_grant,
   output logic              o_any_req
);

   logic w_found;

   assign o_any_req = |i_req;

   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      if (i_rr_mode) begin
         for (int i = 1; i <= NUM_CH; i++) begin
            if (!w_found && i_req[(int'(i_last_grant) + i) % NUM_CH]) begin
               o_grant = GW'((int'(i_last_grant) + i) % NUM_CH);
               w_found = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && i_req[i]) begin
               o_grant = GW'(i);
               w_found = 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/axis_pkt_arbiter.sv
`default_nettype none
//============================================================================
// Module      : axis_pkt_arbiter
// Description : Packet-atomic arbiter merging NUM_CH FWFT packet FIFOs onto
//               one registered AXIS output, with tuser MAC reflection.
// Revision    : 1.0 - initial release
//============================================================================
module axis_pkt_arbiter
   import axis_pkt_arbiter_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int NUM_CH               = 6,
   parameter int ARB_MODE             = 1,
   parameter int REFLECT_CH           = 0
) (
   input  logic                                      axis_aclk,
   input  logic                                      axis_resetn,
   input  logic [NUM_CH*C_S_AXIS_DATA_WIDTH-1:0]     i_tdata,
   input  logic [NUM_CH*C_S_AXIS_TUSER_WIDTH-1:0]    i_tuser,
   input  logic [NUM_CH*C_S_AXIS_DATA_WIDTH/8-1:0]   i_tkeep,
   input  logic [NUM_CH-1:0]                         i_tlast,
   input  logic [NUM_CH-1:0]                         i_pkt_fifo_empty,
   output logic [NUM_CH-1:0]                         o_pkt_fifo_rd_en,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]            o_axis_opl_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]          o_axis_opl_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]           o_axis_opl_tuser,
   output logic                                      o_axis_opl_tvalid,
   output logic                                      o_axis_opl_tlast,
   input  logic                                      i_axis_opl_tready,
   output logic [$clog2(NUM_CH)-1:0]                 o_grant,
   output logic                                      o_busy
);

   localparam int c_DW = C_S_AXIS_DATA_WIDTH;
   localparam int c_KW = C_S_AXIS_DATA_WIDTH / 8;
   localparam int c_UW = C_S_AXIS_TUSER_WIDTH;
   localparam int c_GW = $clog2(NUM_CH);

   if ((ARB_MODE != c_ARB_FIXED && ARB_MODE != c_ARB_RR) || NUM_CH < 2 || NUM_CH > 16
       || c_UW < 32 || REFLECT_CH >= NUM_CH) begin : g_param_chk
      $error("axis_pkt_arbiter: illegal parameter combination");
   end

   arb_state_t        r_state;
   logic [c_GW-1:0]   r_grant;
   logic              r_rr_armed;
   logic [c_DW-1:0]   r_tdata;
   logic [c_KW-1:0]   r_tkeep;
   logic [c_UW-1:0]   r_tuser;
   logic              r_tvalid;
   logic              r_tlast;

   logic              w_can_load;
   logic              w_pop;
   logic              w_any_req;
   logic              w_rr_mode;
   logic [c_GW-1:0]   w_pick;
   logic [c_DW-1:0]   w_head_tdata;
   logic [c_KW-1:0]   w_head_tkeep;
   logic [c_UW-1:0]   w_head_tuser;
   logic              w_head_tlast;
   logic [c_UW-1:0]   w_tuser_out;

   // Until the first grant after reset the rotation has no history, so the
   // search must begin at channel 0 rather than at o_grant+1.
   assign w_rr_mode = (ARB_MODE == c_ARB_RR) && r_rr_armed;

   axis_rr_picker #(
      .NUM_CH (NUM_CH),
      .GW     (c_GW)
   ) u_picker (
      .i_req        (~i_pkt_fifo_empty),
      .i_last_grant (r_grant),
      .i_rr_mode    (w_rr_mode),
      .o_grant      (w_pick),
      .o_any_req    (w_any_req)
   );

   assign w_head_tdata = i_tdata[r_grant*c_DW +: c_DW];
   assign w_head_tkeep = i_tkeep[r_grant*c_KW +: c_KW];
   assign w_head_tuser = i_tuser[r_grant*c_UW +: c_UW];
   assign w_head_tlast = i_tlast[r_grant];

   assign w_can_load = !r_tvalid || i_axis_opl_tready;
   assign w_pop      = (r_state == ST_XFER) && w_can_load && !i_pkt_fifo_empty[r_grant];

   always_comb begin
      w_tuser_out = w_head_tuser;
      if (r_grant == c_GW'(REFLECT_CH))
         w_tuser_out[31:24] = reflect_dst(w_head_tuser[23:16]);
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_rd_en
      assign o_pkt_fifo_rd_en[c] = w_pop && (r_grant == c_GW'(c));
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_state    <= ST_IDLE;
         r_grant    <= '0;
         r_rr_armed <= 1'b0;
         r_tdata    <= '0;
         r_tkeep    <= '0;
         r_tuser    <= '0;
         r_tvalid   <= 1'b0;
         r_tlast    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_state    <= ST_XFER;
                  r_grant    <= w_pick;
                  r_rr_armed <= 1'b1;
               end
            end
            ST_XFER: begin
               if (w_pop && w_head_tlast)
                  r_state <= ST_IDLE;
            end
         endcase

         if (w_pop) begin
            r_tdata  <= w_head_tdata;
            r_tkeep  <= w_head_tkeep;
            r_tuser  <= w_tuser_out;
            r_tlast  <= w_head_tlast;
            r_tvalid <= 1'b1;
         end else if (w_can_load) begin
            r_tvalid <= 1'b0;
         end
      end
   end

   assign o_axis_opl_tdata  = r_tdata;
   assign o_axis_opl_tkeep  = r_tkeep;
   assign o_axis_opl_tuser  = r_tuser;
   assign o_axis_opl_tvalid = r_tvalid;
   assign o_axis_opl_tlast  = r_tlast;
   assign o_grant           = r_grant;
   assign o_busy            = (r_state == ST_XFER);

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_axis_pkt_arbiter
// Description : Self-checking bench: one fixed-priority and one round-robin
//               arbiter fed from modelled FIFOs, checked against a packet model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_axis_pkt_arbiter;

   localparam int NUM_CH  = 6;
   localparam int DW      = 32;
   localparam int UW      = 32;
   localparam int KW      = DW / 8;
   localparam int GW      = $clog2(NUM_CH);
   localparam int NINST   = 2;
   localparam int REFLECT = 0;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [UW-1:0] user;
      logic [KW-1:0] keep;
      logic          last;
      logic          first;
   } word_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst_n;
   logic                 tready;
   logic [NUM_CH*DW-1:0] tdata_in  [NINST];
   logic [NUM_CH*UW-1:0] tuser_in  [NINST];
   logic [NUM_CH*KW-1:0] tkeep_in  [NINST];
   logic [NUM_CH-1:0]    tlast_in  [NINST];
   logic [NUM_CH-1:0]    empty_in  [NINST];
   logic [NUM_CH-1:0]    rd_en     [NINST];
   logic [DW-1:0]        dut_tdata [NINST];
   logic [KW-1:0]        dut_tkeep [NINST];
   logic [UW-1:0]        dut_tuser [NINST];
   logic                 dut_tvalid[NINST];
   logic                 dut_tlast [NINST];
   logic [GW-1:0]        dut_grant [NINST];
   logic                 dut_busy  [NINST];

   // Instance 0 uses fixed priority, instance 1 round-robin.
   for (genvar m = 0; m < NINST; m++) begin : g_dut
      axis_pkt_arbiter #(
         .C_S_AXIS_DATA_WIDTH  (DW),
         .C_S_AXIS_TUSER_WIDTH (UW),
         .NUM_CH               (NUM_CH),
         .ARB_MODE             (m),
         .REFLECT_CH           (REFLECT)
      ) u_dut (
         .axis_aclk         (clk),
         .axis_resetn       (rst_n),
         .i_tdata           (tdata_in[m]),
         .i_tuser           (tuser_in[m]),
         .i_tkeep           (tkeep_in[m]),
         .i_tlast           (tlast_in[m]),
         .i_pkt_fifo_empty  (empty_in[m]),
         .o_pkt_fifo_rd_en  (rd_en[m]),
         .o_axis_opl_tdata  (dut_tdata[m]),
         .o_axis_opl_tkeep  (dut_tkeep[m]),
         .o_axis_opl_tuser  (dut_tuser[m]),
         .o_axis_opl_tvalid (dut_tvalid[m]),
         .o_axis_opl_tlast  (dut_tlast[m]),
         .i_axis_opl_tready (tready),
         .o_grant           (dut_grant[m]),
         .o_busy            (dut_busy[m])
      );
   end

   word_t             fifo     [NINST][NUM_CH][$];
   word_t             stage    [NUM_CH][$];
   int                exp_pop  [NINST][$];
   word_t             exp_out  [NINST][$];
   int                pop_cyc  [NINST][$];
   int                lg       [NINST];
   int                tot_pops [NINST];
   int                busy_cnt [NINST];
   bit                had_pop  [NINST];
   word_t             last_pop [NINST];
   bit                prev_stall[NINST];
   logic [127:0]      prev_out [NINST];
   logic [NUM_CH-1:0] gap_force[NINST];
   logic [NUM_CH-1:0] pop_s    [NINST];
   logic [GW-1:0]     s_grant  [NINST];
   logic              s_busy   [NINST];

   int checks    = 0;
   int failures  = 0;
   int cyc       = 0;
   int ready_pct = 100;
   bit gaps_en   = 1'b0;
   bit ready_low = 1'b0;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   function automatic word_t xform(input word_t w, input int c);
      word_t r = w;
      if (c == REFLECT) begin
         case (w.user[23:16])
            8'h40:   r.user[31:24] = 8'h01;
            8'h01:   r.user[31:24] = 8'h40;
            default: r.user[31:24] = 8'h00;
         endcase
      end
      return r;
   endfunction

   function automatic logic [127:0] wv(input word_t w);
      return {58'd0, 1'b1, w.data, w.user, w.keep, w.last};
   endfunction

   function automatic logic [127:0] cur_out(input int m);
      return {58'd0, dut_tvalid[m], dut_tdata[m], dut_tuser[m], dut_tkeep[m], dut_tlast[m]};
   endfunction

   function automatic int remaining();
      return exp_pop[0].size() + exp_pop[1].size() + exp_out[0].size() + exp_out[1].size();
   endfunction

   task automatic add_pkt(input int c, input int len, input int src);
      for (int i = 0; i < len; i++) begin
         word_t w;
         w.data = $urandom;
         w.user = $urandom;
         if (src >= 0)
            w.user[23:16] = src[7:0];
         else
            case ($urandom_range(0, 2))
               0:       w.user[23:16] = 8'h40;
               1:       w.user[23:16] = 8'h01;
               default: w.user[23:16] = 8'($urandom);
            endcase
         w.keep  = KW'($urandom);
         w.last  = (i == len - 1);
         w.first = (i == 0);
         stage[c].push_back(w);
      end
   endtask

   // Publish staged packets to both FIFO sets at once and derive the packet
   // order each policy must produce from the set of channels with packets.
   task automatic commit();
      for (int m = 0; m < NINST; m++) begin
         word_t tmp [NUM_CH][$];
         int    rem [NUM_CH];
         for (int c = 0; c < NUM_CH; c++) begin
            tmp[c] = stage[c];
            rem[c] = 0;
            foreach (stage[c][k]) begin
               fifo[m][c].push_back(stage[c][k]);
               if (stage[c][k].first) rem[c]++;
            end
         end
         forever begin
            int    pick = -1;
            word_t w;
            for (int i = 0; i < NUM_CH; i++) begin
               int c = (m == 0) ? i : (lg[m] + 1 + i) % NUM_CH;
               if (pick < 0 && rem[c] > 0) pick = c;
            end
            if (pick < 0) break;
            do begin
               w = tmp[pick].pop_front();
               exp_pop[m].push_back(pick);
               exp_out[m].push_back(xform(w, pick));
            end while (!w.last);
            rem[pick]--;
            lg[m] = pick;
         end
      end
      for (int c = 0; c < NUM_CH; c++) stage[c].delete();
   endtask

   task automatic drive();
      for (int m = 0; m < NINST; m++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (fifo[m][c].size() > 0) begin
               word_t h   = fifo[m][c][0];
               bit    gap = gaps_en && ($urandom_range(0, 3) == 0);
               tdata_in[m][c*DW +: DW] = h.data;
               tuser_in[m][c*UW +: UW] = h.user;
               tkeep_in[m][c*KW +: KW] = h.keep;
               tlast_in[m][c]          = h.last;
               empty_in[m][c]          = (gap || gap_force[m][c]) && !h.first;
            end else begin
               tdata_in[m][c*DW +: DW] = '0;
               tuser_in[m][c*UW +: UW] = '0;
               tkeep_in[m][c*KW +: KW] = '0;
               tlast_in[m][c]          = 1'b0;
               empty_in[m][c]          = 1'b1;
            end
         end
      end
      tready = ready_low ? 1'b0 : ($urandom_range(1, 100) <= ready_pct);
   endtask

   task automatic sample(input int m);
      logic [127:0] cur = cur_out(m);
      if (had_pop[m]) check_eq("latency_word", cur, wv(last_pop[m]));
      had_pop[m] = 1'b0;
      if (prev_stall[m]) check_eq("hold_stable", cur, prev_out[m]);
      if (dut_tvalid[m] && !tready) check_eq("stall_rd_en", rd_en[m], '0);
      busy_cnt[m] += int'(dut_busy[m]);
      if (rd_en[m] != '0) begin
         if (exp_pop[m].size() == 0) begin
            check_eq("spurious_pop", rd_en[m], '0);
         end else begin
            int c = exp_pop[m].pop_front();
            check_eq("pop_channel", rd_en[m], 128'(1) << c);
            check_eq("pop_grant", dut_grant[m], c);
            check_eq("pop_busy", dut_busy[m], 1);
            check_eq("pop_nonempty", empty_in[m][c], 0);
            if (fifo[m][c].size() > 0) begin
               last_pop[m] = xform(fifo[m][c][0], c);
               had_pop[m]  = 1'b1;
            end
            pop_cyc[m].push_back(cyc);
            tot_pops[m]++;
         end
      end
      pop_s[m]   = rd_en[m];
      s_grant[m] = dut_grant[m];
      s_busy[m]  = dut_busy[m];
      if (dut_tvalid[m] && tready) begin
         if (exp_out[m].size() == 0)
            check_eq("extra_word", dut_tvalid[m] && tready, 0);
         else
            check_eq("out_word", cur, wv(exp_out[m].pop_front()));
      end
      prev_stall[m] = dut_tvalid[m] && !tready;
      prev_out[m]   = cur;
   endtask

   task automatic step();
      @(negedge clk);
      drive();
      #1;
      for (int m = 0; m < NINST; m++) sample(m);
      @(posedge clk);
      for (int m = 0; m < NINST; m++)
         for (int c = 0; c < NUM_CH; c++)
            if (pop_s[m][c] && fifo[m][c].size() > 0) void'(fifo[m][c].pop_front());
      cyc++;
   endtask

   task automatic drain();
      int n = 0;
      while (remaining() != 0 && n < 3000) begin
         step();
         n++;
      end
      check_eq("drain_timeout", remaining(), 0);
      repeat (3) step();
   endtask

   task automatic wait_pops(input int n);
      int b0 = tot_pops[0];
      int b1 = tot_pops[1];
      int k  = 0;
      while ((tot_pops[0] < b0 + n || tot_pops[1] < b1 + n) && k < 100) begin
         step();
         k++;
      end
      check_eq("wait_pops_timeout", (tot_pops[0] >= b0 + n) && (tot_pops[1] >= b1 + n), 1);
   endtask

   task automatic reset_check(input string tag);
      for (int m = 0; m < NINST; m++) begin
         check_eq({tag, "_out"}, cur_out(m), '0);
         check_eq({tag, "_grant"}, dut_grant[m], 0);
         check_eq({tag, "_rd_en"}, rd_en[m], 0);
         check_eq({tag, "_busy"}, dut_busy[m], 0);
      end
   endtask

   task automatic clear_timing();
      for (int m = 0; m < NINST; m++) begin
         pop_cyc[m].delete();
         busy_cnt[m] = 0;
      end
   endtask

   initial begin
      int gaps_a [4] = '{1, 1, 2, 1};
      rst_n  = 1'b0;
      tready = 1'b0;
      for (int m = 0; m < NINST; m++) begin
         gap_force[m]  = '0;
         lg[m]         = -1;
         tot_pops[m]   = 0;
         had_pop[m]    = 1'b0;
         prev_stall[m] = 1'b0;
         pop_s[m]      = '0;
      end
      drive();
      repeat (3) @(negedge clk);
      #1;
      reset_check("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Two packets, full throughput: exact pop spacing and XFER occupancy.
      clear_timing();
      add_pkt(2, 3, -1);
      add_pkt(5, 2, -1);
      commit();
      drain();
      for (int m = 0; m < NINST; m++) begin
         check_eq("pops_a", pop_cyc[m].size(), 5);
         if (pop_cyc[m].size() == 5)
            for (int i = 0; i < 4; i++)
               check_eq("pop_spacing_a", pop_cyc[m][i+1] - pop_cyc[m][i], gaps_a[i]);
         check_eq("busy_cycles_a", busy_cnt[m], 5);
         check_eq("grant_last_a", s_grant[m], 5);
      end

      // Single-word packets: one XFER cycle each, one IDLE cycle between.
      clear_timing();
      add_pkt(1, 1, -1);
      add_pkt(3, 1, -1);
      commit();
      drain();
      for (int m = 0; m < NINST; m++) begin
         check_eq("pops_b", pop_cyc[m].size(), 2);
         if (pop_cyc[m].size() == 2)
            check_eq("pop_spacing_b", pop_cyc[m][1] - pop_cyc[m][0], 2);
         check_eq("busy_cycles_b", busy_cnt[m], 2);
      end

      // Two packets on each of ch0/ch1 under random backpressure.
      ready_pct = 60;
      add_pkt(0, $urandom_range(1, 4), -1);
      add_pkt(0, $urandom_range(1, 4), -1);
      add_pkt(1, $urandom_range(1, 4), -1);
      add_pkt(1, $urandom_range(1, 4), -1);
      commit();
      drain();

      // Reflection on ch0 versus pass-through on ch1.
      ready_pct = 100;
      add_pkt(0, 2, 8'h40);
      add_pkt(1, 2, 8'h40);
      add_pkt(0, 1, 8'h01);
      commit();
      drain();

      // Downstream stall of four cycles mid-packet on ch3.
      add_pkt(3, 6, -1);
      commit();
      wait_pops(2);
      ready_low = 1'b1;
      repeat (4) begin
         step();
         for (int m = 0; m < NINST; m++) check_eq("stall_no_pop", pop_s[m], 0);
      end
      ready_low = 1'b0;
      drain();

      // ch4 runs dry mid-packet while ch0 becomes ready: grant must stay on ch4.
      add_pkt(4, 4, -1);
      commit();
      wait_pops(2);
      for (int m = 0; m < NINST; m++) gap_force[m][4] = 1'b1;
      add_pkt(0, 2, -1);
      commit();
      repeat (6) begin
         step();
         for (int m = 0; m < NINST; m++) begin
            check_eq("dry_no_pop", pop_s[m], 0);
            check_eq("dry_grant", s_grant[m], 4);
            check_eq("dry_busy", s_busy[m], 1);
         end
      end
      for (int m = 0; m < NINST; m++) gap_force[m][4] = 1'b0;
      drain();

      // Randomised traffic with intra-packet FIFO gaps and backpressure.
      gaps_en = 1'b1;
      for (int it = 0; it < 12; it++) begin
         ready_pct = $urandom_range(30, 100);
         for (int c = 0; c < NUM_CH; c++)
            for (int p = $urandom_range(0, 2); p > 0; p--)
               add_pkt(c, $urandom_range(1, 5), -1);
         commit();
         drain();
      end
      gaps_en   = 1'b0;
      ready_pct = 100;

      // Reset in the middle of a ch1 packet, then restart from channel 0.
      add_pkt(1, 5, -1);
      commit();
      wait_pops(2);
      #2;
      rst_n = 1'b0;
      #1;
      reset_check("reset_mid");
      for (int m = 0; m < NINST; m++) begin
         for (int c = 0; c < NUM_CH; c++) fifo[m][c].delete();
         exp_pop[m].delete();
         exp_out[m].delete();
         had_pop[m]    = 1'b0;
         prev_stall[m] = 1'b0;
         pop_s[m]      = '0;
         lg[m]         = -1;
      end
      drive();
      repeat (2) @(negedge clk);
      #1;
      reset_check("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;
      add_pkt(0, 2, -1);
      add_pkt(1, 2, -1);
      commit();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
